// File: rtl/nn_accel_pkg.sv
// Shared constants and types for the accelerator front-end arbiter.
package nn_accel_pkg;

    localparam int ACC_PIPE_DEPTH = 3;
    localparam int DATA_W_DEF     = 16;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each in-flight operand.
module tag_fifo #(
    parameter  int W     = 2,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign full     = (r_cnt == CW'(DEPTH));
    assign empty    = (r_cnt == '0);
    assign count    = r_cnt;
    assign pop_data = r_mem[r_rd];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    // Explicit wrap so non power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_pop) r_rd <= ptr_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/accel_rr_arbiter.sv
// Round-robin front end sharing one pipelined accelerator between NUM_REQ feeders;
// results are routed back to their owners in issue order via a tag FIFO.
module accel_rr_arbiter
    import nn_accel_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int TAG_DEPTH = ACC_PIPE_DEPTH + 1,
    localparam int TW        = $clog2(NUM_REQ),
    localparam int CW        = $clog2(TAG_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      acc_valid,
    output logic [DATA_W-1:0]         acc_data,
    input  logic                      acc_ready,
    input  logic                      acc_res_valid,
    input  logic [DATA_W-1:0]         acc_res_data,
    output logic                      acc_res_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [CW-1:0]             outstanding,
    output logic                      err_orphan
);

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic [TW-1:0] r_rr_ptr;
    logic [TW-1:0] r_gnt_q;
    logic          r_err_orphan;
    logic [TW-1:0] w_win;
    logic          w_found;
    logic [TW-1:0] w_sel;
    logic          w_issue;
    logic          w_pop;
    logic [TW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_rsp_valid;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = TW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign w_sel     = (r_state == ST_HOLD) ? r_gnt_q : w_win;
    assign acc_valid = reset && !w_full && ((r_state == ST_HOLD) || w_found);
    assign acc_data  = req_data[int'(w_sel)*DATA_W +: DATA_W];
    assign w_issue   = acc_valid && acc_ready;

    always_comb begin
        w_req_ready = '0;
        if (w_issue) w_req_ready[w_sel] = 1'b1;
    end
    assign req_ready = w_req_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:  if (acc_valid && !acc_ready) w_state_nxt = ST_HOLD;
            ST_HOLD: if (acc_ready) w_state_nxt = ST_ARB;
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_ARB;
            r_rr_ptr     <= '0;
            r_gnt_q      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARB && acc_valid && !acc_ready) r_gnt_q <= w_win;
            if (w_issue) r_rr_ptr <= (w_sel == TW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            if (acc_res_valid && w_empty) r_err_orphan <= 1'b1;
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        if (!w_empty) w_rsp_valid[w_head] = acc_res_valid;
    end
    assign rsp_valid     = w_rsp_valid;
    assign acc_res_ready = !w_empty && rsp_ready[w_head];
    assign w_pop         = acc_res_valid && acc_res_ready;
    assign rsp_data      = acc_res_data;
    assign err_orphan    = r_err_orphan;

    tag_fifo #(
        .W     (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (w_issue),
        .push_data (w_sel),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (outstanding)
    );

endmodule

// File: doc/accel_rr_arbiter.md
# accel_rr_arbiter

Round-robin arbiter that shares one 3-stage neural accelerator pipeline between NUM_REQ independent feeders. Sits between the feeders and the accelerator's valid/ready input. Tags each accepted operand with its requester index, and routes each result back to that requester in issue order. Tags are kept in an internal FIFO sized to cover the pipeline's in-flight capacity.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand/result width
- TAG_DEPTH, 4, tag FIFO entries (must be ≥ accelerator pipeline depth 3 + 1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*DATA_W  packed operands; requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept
- acc_valid  out  1  operand valid to accelerator
- acc_data  out  DATA_W  operand to accelerator
- acc_ready  in  1  accelerator accepts operand
- acc_res_valid  in  1  accelerator result valid
- acc_res_data  in  DATA_W  accelerator result
- acc_res_ready  out  1  result accepted
- rsp_valid  out  NUM_REQ  result valid, one-hot on owning requester
- rsp_data  out  DATA_W  shared result bus; equals acc_res_data
- rsp_ready  in  NUM_REQ  per-requester result accept
- outstanding  out  $clog2(TAG_DEPTH+1)  tags in flight
- err_orphan  out  1  sticky: result arrived with empty tag FIFO

## Operation
- States: ARB and HOLD.
- ARB:
  - Eligible requester = first i with req_valid[i], searched from rr_ptr upward, wrapping modulo NUM_REQ.
  - If any requester is eligible and the tag FIFO is not full, acc_valid=1 and acc_data=req_data of the winner.
  - If acc_ready=1, issue: req_ready[winner]=1, the winner index is pushed to the FIFO, rr_ptr←winner+1 (mod NUM_REQ), and the FSM stays in ARB.
  - If acc_ready=0, latch the winner into gnt_q and go to HOLD.
- HOLD:
  - The grant is frozen on gnt_q; acc_valid=1 and acc_data=req_data[gnt_q], regardless of other requests.
  - On acc_ready=1: issue as above using gnt_q, then return to ARB.
  - Requesters must not drop req_valid while granted. The arbiter does not check for this.
- acc_valid never depends combinationally on acc_ready.
- FIFO full: acc_valid=0 and all req_ready=0, in either state.
  - Entering HOLD requires acc_valid=1, so HOLD is only entered with the FIFO not full.
  - The FIFO cannot become full while in HOLD, because only an issue pushes.
- Response path, FIFO not empty with head tag t:
  - rsp_valid[t]=acc_res_valid; all other rsp_valid bits are 0.
  - acc_res_ready=rsp_ready[t].
  - On acc_res_valid && rsp_ready[t], pop the FIFO.
- Response path, FIFO empty:
  - acc_res_ready=0 and rsp_valid=0.
  - If acc_res_valid=1, err_orphan←1. It stays set until reset.
- Simultaneous push and pop:
  - Both take effect in the same cycle.
  - outstanding is unchanged.
  - Allowed at any non-full, non-empty occupancy.
- Push while full is impossible by construction. There is no bypass from issue to response.

## Timing
- Reset (reset=0) asynchronously clears everything:
  - State returns to ARB; rr_ptr=0; gnt_q=0.
  - The FIFO is emptied; outstanding=0; err_orphan=0.
  - All outputs read 0: req_ready, acc_valid, acc_res_ready and rsp_valid.
- Reset mid-operation discards all in-flight tags. Results still arriving from the accelerator after reset set err_orphan.
- Arbitration has zero latency: a request on an idle bus is presented to the accelerator in the same cycle.
- The response path is combinational from acc_res_valid/rsp_ready to rsp_valid/acc_res_ready.
- outstanding updates on the clock edge after a push or pop.
- Sustained throughput is one issue per cycle while acc_ready=1 and the FIFO is not full.

## Structure
- Package nn_accel_pkg holds:
  - ACC_PIPE_DEPTH=3
  - Default DATA_W
  - The arbiter state enum typedef (ARB, HOLD)
- Sub-module tag_fifo: a synchronous FIFO, width $clog2(NUM_REQ) and depth TAG_DEPTH, providing full, empty and count.
- Round-robin select and response demux live in the top module.

## Test plan
- Single requester: req_valid=4'b0100, acc_ready=1 → acc_valid in the same cycle with acc_data=req_data[2]. After 3 cycles the result appears on rsp_valid=4'b0100. outstanding goes 1 then 0.
- All four requesting continuously with acc_ready=1 and rsp_ready=all ones → grant order 0,1,2,3,0,1… Results return tagged in the same order.
- Backpressure: requester 1 granted, acc_ready=0 for 5 cycles while requester 0 raises valid → acc_data stays req_data[1]. On acc_ready=1, requester 1 is issued and rr_ptr becomes 2.
- FIFO fill: acc_res_valid held 0 and 4 issues made → outstanding=4, acc_valid=0, req_ready=0. One result is popped → issuing resumes next cycle.
- Simultaneous push and pop at outstanding=2 → outstanding stays 2 and no tag is lost or duplicated.
- acc_res_valid=1 with an empty FIFO → acc_res_ready=0, err_orphan=1 and held. Asserting reset low clears it to 0.
